// File: rtl/adc_spi_pkg.sv
// Shared constants for the adc_spi master/responder pair: frame layout,
// channel codes and the responder state encoding.
package adc_spi_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_MSB   = 13;
  localparam int unsigned ADDR_LSB   = 11;
  localparam int unsigned NUM_CH     = 8;

  localparam logic [2:0] CH_0 = 3'd0;
  localparam logic [2:0] CH_1 = 3'd1;
  localparam logic [2:0] CH_2 = 3'd2;
  localparam logic [2:0] CH_3 = 3'd3;
  localparam logic [2:0] CH_4 = 3'd4;
  localparam logic [2:0] CH_5 = 3'd5;
  localparam logic [2:0] CH_6 = 3'd6;
  localparam logic [2:0] CH_7 = 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/adc_spi_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line, with a history flop
// providing single-clk rise/fall strobes.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      hist  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      hist  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];
  assign rise     =  chain[SYNC_STAGES-1] & ~hist;
  assign fall     = ~chain[SYNC_STAGES-1] &  hist;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating an 8-channel 12-bit ADC128S-style converter; the
// sample returned in each frame belongs to the address sent in the previous one.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     SS_n,
  input  logic                     SCLK,
  input  logic                     MOSI,
  output logic                     MISO,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     frame_done,
  output logic [2:0]               last_chnl
);

  logic       ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
  logic [3:0] sync_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .async_in(SS_n),
    .sync_out(sync_unused[0]), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_in(SCLK),
    .sync_out(sync_unused[1]), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .async_in(MOSI),
    .sync_out(mosi_s), .rise(sync_unused[2]), .fall(sync_unused[3])
  );

  state_t                  state, state_next;
  logic [2:0]              next_addr;
  logic [3:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   tx_shift;
  // Only the bits that can still reach ADD2..ADD0 by the 16th rise are kept.
  logic [ADDR_MSB-1:0]     rx_shift;
  logic [2:0]              word_addr, load_addr;
  logic [DATA_W-1:0]       sample;
  logic                    do_load, do_shift, do_complete, do_drive, do_clear;

  assign word_addr = rx_shift[ADDR_MSB-1:ADDR_LSB-1];
  assign load_addr = do_complete ? word_addr : next_addr;

  always_comb begin
    sample = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (load_addr == 3'(i)) sample = ch_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    do_load     = 1'b0;
    do_shift    = 1'b0;
    do_complete = 1'b0;
    do_drive    = 1'b0;
    do_clear    = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next = SHIFT;
          do_load    = 1'b1;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          do_shift    = 1'b1;
          do_complete = (bit_cnt == 4'(FRAME_BITS-1));
        end else if (sclk_fall) begin
          do_drive = 1'b1;
        end
        // A deselect coinciding with the 16th rise still completes the frame.
        if (ss_rise) begin
          state_next = IDLE;
          do_drive   = 1'b0;
          do_clear   = 1'b1;
        end else if (do_complete) begin
          do_load = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MISO       <= 1'b0;
      frame_done <= 1'b0;
      last_chnl  <= '0;
      next_addr  <= '0;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
    end else begin
      frame_done <= do_complete;
      if (do_complete) begin
        next_addr <= word_addr;
        last_chnl <= word_addr;
      end
      if (do_shift) begin
        rx_shift <= {rx_shift[ADDR_MSB-2:0], mosi_s};
        bit_cnt  <= bit_cnt + 4'd1;
      end
      if (do_drive) MISO <= tx_shift[4'(FRAME_BITS-1) - bit_cnt];
      if (do_clear) begin
        bit_cnt <= '0;
        MISO    <= 1'b0;
      end
      if (do_load) begin
        tx_shift <= {{(FRAME_BITS-DATA_W){1'b0}}, sample};
        bit_cnt  <= '0;
        MISO     <= 1'b0;
      end
    end
  end

endmodule
